filter_sync: RTL and testbench
==============================

Name: filter_sync

Overview:
- Brings a multi-bit bus, driven asynchronously from a foreign domain, into the local `clk` domain.
- Each bit passes through a multi-flop synchronizer chain.
- A stability filter then forwards a bus value only after it has held unchanged for a set number of consecutive cycles.
- Skewed or transient intermediate codes are never presented downstream.
- Sits at the receiving edge of a clock-domain crossing for slow-changing status/config buses.

Parameters:
- WIDTH, 4, bus width in bits (>=1).
- SYNC_STAGES, 2, flops per bit in the synchronizer chain (>=2).
- STABLE_CYCLES, 2, consecutive identical synchronized samples required before the output updates (>=1).

Ports:
- clk  input  1  receiving-domain clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  WIDTH  asynchronous source bus; may change at any time relative to clk.
- synchronized_bus  output  WIDTH  filtered, synchronized bus value (registered).
- bus_updated  output  1  single-cycle pulse, high in the cycle synchronized_bus takes a new value.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; all registers use it.
- Reset values:
  - sync chain flops = 0
  - candidate register cand = 0
  - counter cnt = 0
  - synchronized_bus = 0
  - bus_updated = 0
- Reset asserted mid-operation clears all state on the next rising edge. Any in-progress filtering is discarded and no pulse is emitted.
- Sync chain:
  - stage[0] <= bus_in.
  - stage[i] <= stage[i-1].
  - s = stage[SYNC_STAGES-1].
  - No logic between stages.
- Filter, each rising edge when rst=0:
  - If s != cand: cand <= s, cnt <= 1.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - Else cnt holds (saturates at STABLE_CYCLES).
- Output, evaluated on current register values:
  - If cnt == STABLE_CYCLES and cand != synchronized_bus: synchronized_bus <= cand, bus_updated <= 1.
  - Otherwise synchronized_bus holds and bus_updated <= 0.
- Counter width: $clog2(STABLE_CYCLES+1) bits; never wraps.
- Latency:
  - If bus_in settles to V before rising edge E0 and then stays constant, synchronized_bus = V after edge E0+SYNC_STAGES+STABLE_CYCLES.
  - Defaults: 4 edges after the first sampling edge.
  - bus_updated is high for exactly that one cycle.
- Rejection:
  - Any change of s before cnt reaches STABLE_CYCLES restarts counting from the new value.
  - A synchronized value lasting fewer than STABLE_CYCLES cycles never reaches the output.
- No repeated pulses: a value equal to the current output never generates bus_updated, including a return to the old value after a rejected glitch.
- bus_in values are never combinationally visible at any output.

Decomposition:
- Package filter_sync_pkg holds:
  - default constants DEFAULT_WIDTH=4, DEFAULT_SYNC_STAGES=2, DEFAULT_STABLE_CYCLES=2.
  - a function computing the counter width.
- One sub-module, sync_chain:
  - parameters WIDTH and SYNC_STAGES; ports clk, rst, d, q.
  - vector of per-bit flop chains, instantiated once in filter_sync.
- The filter/counter/output logic lives in filter_sync itself.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 3 cycles with bus_in=4'b1111.
  - Required: synchronized_bus=4'b0000 and bus_updated=0 throughout; after release, output becomes 4'b1111 exactly 4 edges later with one bus_updated pulse.
- Basic transfer (defaults):
  - Stimulus: after reset with bus_in=0, set bus_in=4'b1010 before edge E0.
  - Required: synchronized_bus=4'b1010 after E0+4, with bus_updated high for that single cycle and 0 before and after.
- Glitch rejection:
  - Stimulus: output stable at 4'b1010; drive bus_in=4'b0101 for exactly one cycle, then return to 4'b1010.
  - Required: synchronized_bus stays 4'b1010; bus_updated never asserts.
- Skew filtering:
  - Stimulus: from 4'b0000, bus_in goes 4'b0010 for one cycle, then 4'b1010 and holds.
  - Required: output goes directly 4'b0000→4'b1010, never shows 4'b0010; exactly one pulse.
- Stable hold:
  - Stimulus: keep bus_in=4'b1010 for 50 cycles after the update.
  - Required: no further bus_updated pulses; cnt saturates.
- Reset mid-operation:
  - Stimulus: change bus_in to 4'b0110, then assert rst two edges later.
  - Required: output returns to 4'b0000 with no pulse; after release, 4'b0110 appears 4 edges later.

Source files
------------

// File: rtl/filter_sync_pkg.sv
// Shared defaults and helpers for the filtered bus synchronizer.
package filter_sync_pkg;

    localparam int DEFAULT_WIDTH         = 4;
    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 2;

    // Width needed to hold a count from 0 up to stable_cycles inclusive.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/filter_sync_sync_chain.sv
// Per-bit multi-flop synchronizer chain; plain flop-to-flop, no logic between stages.
module sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the asynchronous bus through SYNC_STAGES flops per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/filter_sync.sv
// Synchronizes an asynchronous bus and forwards a value only after it has
// been seen unchanged for STABLE_CYCLES consecutive synchronized samples.
module filter_sync
    import filter_sync_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] synchronized_bus,
    output logic             bus_updated
);

    localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             upd_q, upd_d;

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (bus_in),
        .q   (s)
    );

    // Track the current candidate value and how long it has been stable (saturating).
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (s != cand_q) begin
            cand_d = s;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Publish a fully stable candidate once, only when it differs from what is already shown.
    always_comb begin
        out_d = out_q;
        upd_d = 1'b0;
        if ((cnt_q == CNT_MAX) && (cand_q != out_q)) begin
            out_d = cand_q;
            upd_d = 1'b1;
        end
    end

    // State registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            upd_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            upd_q  <= upd_d;
        end
    end

    assign synchronized_bus = out_q;
    assign bus_updated      = upd_q;

endmodule

// File: tb/tb_filter_sync.sv
// Self-checking bench for filter_sync with a sliding-window reference model.
module tb_filter_sync;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SC = 2;
    localparam int L  = SS + SC;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] bus_in;
    logic [W-1:0] synchronized_bus;
    logic         bus_updated;

    int total = 0;
    int bad   = 0;

    filter_sync #(
        .WIDTH         (W),
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_in           (bus_in),
        .synchronized_bus (synchronized_bus),
        .bus_updated      (bus_updated)
    );

    always #5 clk = ~clk;

    // Reference model: hist[L-1] is the bus_in value sampled at the previous edge,
    // hist[0] the one sampled L edges ago. An edge publishes V when the SC samples
    // taken SS+1 .. SS+SC edges earlier all equal V and V differs from the output.
    logic [W-1:0] hist [L];
    logic [W-1:0] exp_out;
    logic         exp_upd;
    logic         all_eq;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) hist[i] = '0;
            exp_out = '0;
            exp_upd = 1'b0;
        end else begin
            all_eq = 1'b1;
            for (int i = 1; i < SC; i++) if (hist[i] !== hist[0]) all_eq = 1'b0;
            if (all_eq && (hist[0] !== exp_out)) begin
                exp_out = hist[0];
                exp_upd = 1'b1;
            end else begin
                exp_upd = 1'b0;
            end
            for (int i = 0; i < L - 1; i++) hist[i] = hist[i+1];
            hist[L-1] = bus_in;
        end
    end

    task automatic reset_to(input logic [W-1:0] v, input int n);
        @(negedge clk);
        rst    = 1'b1;
        bus_in = v;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst    = 1'b1;
        bus_in = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (synchronized_bus !== 4'b0000 || bus_updated !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold got=%h/%b exp=0/0", synchronized_bus, bus_updated);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            total++;
            if (synchronized_bus !== ((i >= 5) ? 4'b1111 : 4'b0000) || bus_updated !== (i == 5)) begin
                bad++;
                $display("FAIL reset_release edge=%0d got=%h/%b exp=%h/%b", i, synchronized_bus,
                         bus_updated, (i >= 5) ? 4'b1111 : 4'b0000, (i == 5));
            end
            total++;
            if (synchronized_bus !== exp_out || bus_updated !== exp_upd) begin
                bad++;
                $display("FAIL reset_model got=%h/%b exp=%h/%b", synchronized_bus, bus_updated, exp_out, exp_upd);
            end
        end
    endtask

    task automatic test_basic();
        reset_to(4'b0000, 2);
        bus_in = 4'b1010;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            total++;
            if (synchronized_bus !== ((i >= 5) ? 4'b1010 : 4'b0000) || bus_updated !== (i == 5)) begin
                bad++;
                $display("FAIL basic edge=%0d got=%h/%b exp=%h/%b", i, synchronized_bus,
                         bus_updated, (i >= 5) ? 4'b1010 : 4'b0000, (i == 5));
            end
        end
    endtask

    task automatic test_glitch();
        bus_in = 4'b0101;
        @(negedge clk);
        bus_in = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (synchronized_bus !== 4'b1010 || bus_updated !== 1'b0) begin
                bad++;
                $display("FAIL glitch got=%h/%b exp=a/0", synchronized_bus, bus_updated);
            end
        end
    endtask

    task automatic test_skew();
        int pulses = 0;
        int seen_mid = 0;
        reset_to(4'b0000, 2);
        bus_in = 4'b0010;
        @(negedge clk);
        if (synchronized_bus === 4'b0010) seen_mid++;
        bus_in = 4'b1010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_updated === 1'b1) pulses++;
            if (synchronized_bus === 4'b0010) seen_mid++;
        end
        total++;
        if (seen_mid !== 0) begin
            bad++;
            $display("FAIL skew_mid_code got=%0d cycles exp=0", seen_mid);
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL skew_pulses got=%0d exp=1", pulses);
        end
        total++;
        if (synchronized_bus !== 4'b1010) begin
            bad++;
            $display("FAIL skew_final got=%h exp=a", synchronized_bus);
        end
    endtask

    task automatic test_stable_hold();
        int pulses = 0;
        bus_in = 4'b1010;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_updated !== 1'b0) pulses++;
        end
        total++;
        if (pulses !== 0 || synchronized_bus !== 4'b1010) begin
            bad++;
            $display("FAIL stable_hold pulses=%0d out=%h exp pulses=0 out=a", pulses, synchronized_bus);
        end
    endtask

    task automatic test_reset_mid();
        bus_in = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (synchronized_bus !== 4'b1010 || bus_updated !== 1'b0) begin
            bad++;
            $display("FAIL mid_before got=%h/%b exp=a/0", synchronized_bus, bus_updated);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (synchronized_bus !== 4'b0000 || bus_updated !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset got=%h/%b exp=0/0", synchronized_bus, bus_updated);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            total++;
            if (synchronized_bus !== ((i >= 5) ? 4'b0110 : 4'b0000) || bus_updated !== (i == 5)) begin
                bad++;
                $display("FAIL mid_release edge=%0d got=%h/%b exp=%h/%b", i, synchronized_bus,
                         bus_updated, (i >= 5) ? 4'b0110 : 4'b0000, (i == 5));
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            total++;
            if (synchronized_bus !== exp_out || bus_updated !== exp_upd) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h/%b exp=%h/%b", i, synchronized_bus, bus_updated,
                         exp_out, exp_upd);
            end
            rst = ($urandom_range(0, 79) == 0);
            if (hold == 0) begin
                bus_in = W'($urandom_range(0, (1 << W) - 1));
                hold   = $urandom_range(1, 5);
            end
            hold--;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        bus_in = '0;
        test_reset();
        test_basic();
        test_glitch();
        test_stable_hold();
        test_skew();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
